// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the responder's FSM state types.
package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } r_state_e;

endpackage

// File: rtl/axil_byte_ram.sv
// Word-addressed synchronous RAM with per-byte write enables and a registered read port.
// Reset clears only the read register; the array contents survive reset.
module axil_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read samples the array before this edge's write lands, so a same-word
  // read/write pair returns the old data.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axil_mem_responder.sv
// AXI4-Lite responder fronting a byte-writable RAM: one outstanding read and one write.
// Build option AXIL_MEM_ERR_RESP_EN: SLVERR and suppressed access outside the RAM window.
//
//   state     | meaning
//   W_IDLE    | waiting for AW and/or W
//   W_HAVE_AW | address latched, waiting for W
//   W_HAVE_W  | data/strobe latched, waiting for AW
//   W_RESP    | B response presented until bready
//   R_IDLE    | waiting for AR
//   R_VALID   | R response presented until rready
module axil_mem_responder
  import axil_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
`ifdef AXIL_MEM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  // Unsigned offset compare also rejects addresses below BASE_ADDR (they wrap high).
  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return !ERR_EN || ({1'b0, off} < SPAN);
  endfunction

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        live_q, live_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rzero_q, rzero_d;

  logic          wr_go;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_rdata;

  // live_q holds readies low for the reset cycle itself; they rise one edge later.
  assign live_d = 1'b1;

  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    wr_go     = 1'b0;
    wr_addr   = s_awaddr;
    wr_data   = s_wdata;
    wr_strb   = s_wstrb;
    case (w_state_q)
      W_IDLE: begin
        s_awready = live_q;
        s_wready  = live_q;
        if (live_q) begin
          if (s_awvalid && s_wvalid) begin
            wr_go = 1'b1;
          end else if (s_awvalid) begin
            aw_addr_d = s_awaddr;
            w_state_d = W_HAVE_AW;
          end else if (s_wvalid) begin
            wdata_d   = s_wdata;
            wstrb_d   = s_wstrb;
            w_state_d = W_HAVE_W;
          end
        end
      end
      W_HAVE_AW: begin
        s_wready = 1'b1;
        wr_addr  = aw_addr_q;
        wr_go    = s_wvalid;
      end
      W_HAVE_W: begin
        s_awready = 1'b1;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;
        wr_go     = s_awvalid;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (wr_go) begin
      w_state_d = W_RESP;
      bresp_d   = addr_ok(wr_addr) ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
    end
    ram_we    = wr_go && !rst && addr_ok(wr_addr);
    ram_waddr = word_idx(wr_addr);
  end

  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    rzero_d   = rzero_q;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = word_idx(s_araddr);
    case (r_state_q)
      R_IDLE: begin
        s_arready = live_q;
        if (live_q && s_arvalid) begin
          ram_re    = !rst;
          r_state_d = R_VALID;
          rresp_d   = addr_ok(s_araddr) ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
          rzero_d   = !addr_ok(s_araddr);
        end
      end
      R_VALID: begin
        s_rvalid = 1'b1;
        if (s_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= AXIL_RESP_OKAY;
      rresp_q   <= AXIL_RESP_OKAY;
      rzero_q   <= 1'b0;
    end else begin
      live_q    <= live_d;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_addr_q <= aw_addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rzero_q   <= rzero_d;
    end
  end

  axil_byte_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign s_bresp = bresp_q;
  assign s_rresp = rresp_q;
  assign s_rdata = rzero_q ? 32'h0000_0000 : ram_rdata;

endmodule

// File: tb/tb_axil_mem_responder.sv
// Self-checking bench for axil_mem_responder: directed scenarios plus randomized traffic
// against a word-array model of the memory; follows AXIL_MEM_ERR_RESP_EN like the RTL.
module tb_axil_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          POOL  = 32;
`ifdef AXIL_MEM_ERR_RESP_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  axil_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % DEPTH);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] resp);
    int k;
    logic [31:0] w;
    resp = (ERR && !in_rng(a)) ? 2'b10 : 2'b00;
    if (ERR && !in_rng(a)) return;
    k = widx(a);
    w = mem_m[k];
    for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = d[8*i +: 8];
    mem_m[k] = w;
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    if (ERR && !in_rng(a)) begin
      d = 32'h0;
      resp = 2'b10;
    end else begin
      d = mem_m[widx(a)];
      resp = 2'b00;
    end
  endtask

  // Called at posedge+1; AW and W raised after independent cycle delays.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int da, input int dw, input int hold);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int c = 0;
    logic [1:0] exp_r;
    while (!(aw_done && w_done)) begin
      s_awaddr = a; s_wdata = d; s_wstrb = st;
      s_awvalid = !aw_done && (c >= da);
      s_wvalid  = !w_done && (c >= dw);
      #1;
      if (aw_done) chk("awready_low_have_aw", s_awready, 0);
      if (w_done)  chk("wready_low_have_w", s_wready, 0);
      hs_aw = s_awvalid && s_awready;
      hs_w  = s_wvalid && s_wready;
      @(posedge clk); #1;
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      c++;
      if (c > 60) begin
        chk("write_handshake_timeout", 0, 1);
        break;
      end
    end
    s_awvalid = 0; s_wvalid = 0;
    model_write(a, d, st, exp_r);
    chk("bvalid_latency", s_bvalid, 1);
    chk("bresp", s_bresp, exp_r);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", s_bvalid, 1);
      chk("bresp_hold", s_bresp, exp_r);
      chk("awready_in_resp", s_awready, 0);
      chk("wready_in_resp", s_wready, 0);
    end
    s_bready = 1;
    @(posedge clk); #1;
    s_bready = 0;
    chk("bvalid_drop", s_bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] got);
    int c = 0;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    s_araddr = a; s_arvalid = 1;
    #1;
    while (!s_arready) begin
      @(posedge clk); #1;
      c++;
      if (c > 60) begin
        chk("read_handshake_timeout", 0, 1);
        break;
      end
    end
    model_read(a, exp_d, exp_r);
    @(posedge clk); #1;
    s_arvalid = 0;
    chk("rvalid_latency", s_rvalid, 1);
    chk("rdata", s_rdata, exp_d);
    chk("rresp", s_rresp, exp_r);
    got = s_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", s_rvalid, 1);
      chk("rdata_hold", s_rdata, exp_d);
      chk("arready_in_rvalid", s_arready, 0);
    end
    s_rready = 1;
    @(posedge clk); #1;
    s_rready = 0;
    chk("rvalid_drop", s_rvalid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, old0, ed;
    logic [1:0]  er;
    int rv_cnt;
    rst = 1;
    s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arvalid = 0; s_rready = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", s_awready, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_bresp", s_bresp, 0);
    chk("rst_rresp", s_rresp, 0);
    chk("rst_rdata", s_rdata, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_awready", s_awready, 1);
    chk("post_rst_wready", s_wready, 1);
    chk("post_rst_arready", s_arready, 1);

    // Fill the working word pool so every later read has known contents.
    for (int i = 0; i < POOL; i++) axi_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);

    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_read(32'h10, 0, got);
    chk("readback_deadbeef", got, 32'hDEAD_BEEF);

    axi_write(32'h20, 32'hAAAA_AAAA, 4'hF, 0, 0, 0);
    axi_write(32'h20, 32'h1122_3344, 4'h3, 0, 3, 0);
    axi_read(32'h20, 1, got);
    chk("readback_partial", got, 32'hAAAA_3344);

    axi_write(32'h24, 32'hCAFE_0001, 4'hF, 3, 0, 4);

    // Same-edge read and write of one word: the read sees the old value.
    axi_write(32'h30, 32'h5, 4'hF, 0, 0, 0);
    s_awaddr = 32'h30; s_wdata = 32'h9; s_wstrb = 4'hF; s_araddr = 32'h30;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    #1;
    chk("concurrent_ready", {29'b0, s_awready, s_wready, s_arready}, 32'h7);
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    model_write(32'h30, 32'h9, 4'hF, er);
    chk("concurrent_rvalid", s_rvalid, 1);
    chk("concurrent_bvalid", s_bvalid, 1);
    chk("concurrent_rdata_old", s_rdata, 32'h5);
    s_bready = 1; s_rready = 1;
    @(posedge clk); #1;
    s_bready = 0; s_rready = 0;
    axi_read(32'h30, 0, got);
    chk("concurrent_readback_new", got, 32'h9);

    old0 = mem_m[0];
    axi_write(32'h1000, 32'h1234_5678, 4'hF, 0, 0, 0);
    axi_read(32'h0, 0, got);
    chk("oob_write_word0", got, ERR ? old0 : 32'h1234_5678);

    // Back-to-back reads with rready held: one beat every two cycles.
    s_araddr = 32'h44; s_arvalid = 1; s_rready = 1;
    model_read(32'h44, ed, er);
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (s_rvalid) begin
        rv_cnt++;
        chk("b2b_rdata", s_rdata, ed);
      end
    end
    s_arvalid = 0; s_rready = 0;
    chk("b2b_beats", rv_cnt, 4);

    // Reset while a read response is pending.
    s_araddr = 32'h48; s_arvalid = 1;
    @(posedge clk); #1;
    s_arvalid = 0;
    chk("pre_rst_rvalid", s_rvalid, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_rvalid", s_rvalid, 0);
    chk("mid_rst_arready", s_arready, 0);
    chk("mid_rst_rdata", s_rdata, 0);
    @(posedge clk); #1;
    chk("after_rst_arready", s_arready, 1);
    axi_read(32'h48, 0, got);

    for (int it = 0; it < 80; it++) begin
      logic [31:0] a;
      int idx;
      idx = $urandom_range(0, POOL - 1);
      if ($urandom_range(0, 99) < 15) a = BASE + 32'h1000 + 32'(4 * idx);
      else a = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
